// File: rtl/hk_pkg.sv
// hk_pkg: shared constants and types for the
// red_pitaya_hk_gpio housekeeping block.
package hk_pkg;
  localparam logic [7:0] HK_VER = 8'h02;
  localparam int HK_DEB_CYC = 16;
  localparam int DNA_BITS = 57;

  localparam logic [19:0] A_ID = 20'h00000;
  localparam logic [19:0] A_DNA_LO = 20'h00004;
  localparam logic [19:0] A_DNA_HI = 20'h00008;
  localparam logic [19:0] A_LOOP = 20'h0000C;
  localparam logic [19:0] A_LED = 20'h00030;
  localparam logic [19:0] A_RDY = 20'h00100;

  localparam logic [19:0] BANK_BASE = 20'h00200;
  localparam logic [19:0] BANK_STRIDE = 20'h00020;

  localparam logic [4:0] B_DIR = 5'h00;
  localparam logic [4:0] B_OUT = 5'h04;
  localparam logic [4:0] B_IN = 5'h08;
  localparam logic [4:0] B_REN = 5'h0C;
  localparam logic [4:0] B_FEN = 5'h10;
  localparam logic [4:0] B_STS = 5'h14;
  localparam logic [4:0] B_SET = 5'h18;
  localparam logic [4:0] B_CLR = 5'h1C;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    DONE
  } dna_state_t;
endpackage

// File: rtl/red_pitaya_hk_gpio_if.sv
// red_pitaya_hk_gpio_if: system bus bundle
// between a bus master and the housekeeping block.
interface red_pitaya_hk_gpio_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic sys_wen;
  logic sys_ren;
  logic [31:0] sys_rdata;
  logic sys_err;
  logic sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/hk_dna_reader.sv
// hk_dna_reader: divided-clock DNA_PORT model plus
// the LOAD/SHIFT/DONE readout FSM, MSB first.
module hk_dna_reader
  import hk_pkg::*;
#(
  parameter logic [DNA_BITS-1:0] DNA = 57'h0823456789ABCDE,
  parameter int DNA_DIV = 8
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic [DNA_BITS-1:0] dna_value_o,
  output logic dna_done_o
);
  localparam int CW = $clog2(DNA_DIV);
  localparam logic [CW-1:0] SMP = CW'(DNA_DIV/2-1);
  localparam logic [CW-1:0] LAST = CW'(DNA_DIV-1);

  dna_state_t state_q, state_d;
  logic [CW-1:0] div_q;
  logic [5:0] cnt_q, cnt_d;
  logic [DNA_BITS-1:0] val_q, val_d;
  logic [DNA_BITS-1:0] port_q;
  logic dclk, dclk_q, rd, sh, dout;

  assign dclk = (state_q != DONE) & div_q[CW-1];
  assign dout = port_q[DNA_BITS-1];

  // free-running divider and FSM state
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      div_q <= '0;
      state_q <= LOAD;
      cnt_q <= '0;
      val_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
      state_q <= state_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
    end
  end

  // DNA_PORT: loads or shifts on each dna_clk rising edge
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      port_q <= '0;
      dclk_q <= 1'b0;
    end else begin
      dclk_q <= dclk;
      if (dclk && !dclk_q) begin
        if (rd) port_q <= DNA;
        else if (sh) port_q <= {port_q[DNA_BITS-2:0], 1'b0};
      end
    end
  end

  // next state; DOUT sampled just before each rising edge
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    val_d = val_q;
    rd = 1'b0;
    sh = 1'b0;
    unique case (state_q)
      LOAD: begin
        rd = 1'b1;
        if (div_q == LAST) state_d = SHIFT;
      end
      SHIFT: begin
        sh = 1'b1;
        if (div_q == SMP) begin
          val_d = {val_q[DNA_BITS-2:0], dout};
          cnt_d = cnt_q + 6'd1;
        end
        if (div_q == LAST && cnt_q == 6'(DNA_BITS))
          state_d = DONE;
      end
      DONE: ;
      default: state_d = LOAD;
    endcase
  end

  assign dna_value_o = val_q;
  assign dna_done_o = (state_q == DONE);
endmodule

// File: rtl/red_pitaya_hk_gpio.sv
// red_pitaya_hk_gpio: ID, DNA, LEDs and GPIO banks.
// Optional input debounce: HK_GPIO_DEBOUNCE_EN.
module red_pitaya_hk_gpio
  import hk_pkg::*;
#(
  parameter int DWL = 8,
  parameter int DWE = 8,
  parameter int NBANK = 2,
  parameter logic [DNA_BITS-1:0] DNA = 57'h0823456789ABCDE,
  parameter int DNA_DIV = 8
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic [DWL-1:0] led_o,
  output logic digital_loop,
  input  logic [NBANK*DWE-1:0] exp_dat_i,
  output logic [NBANK*DWE-1:0] exp_dat_o,
  output logic [NBANK*DWE-1:0] exp_dir_o,
  output logic irq_o,
  red_pitaya_hk_gpio_if.slave bus
);
  logic [19:0] a, boff;
  logic [4:0] boffs;
  logic [2:0] bidx;
  logic in_bank;
  logic [DNA_BITS-1:0] dna_val;
  logic dna_done;
  logic [NBANK:0][31:0] rd_acc;
  logic [NBANK-1:0] bank_irq;
  logic [DWL-1:0] led_q;
  logic loop_q, rdy_q, ack_q, irq_q;
  logic [31:0] rdata_q, rdata_d;
  logic unused_ok;

  assign a = bus.sys_addr[19:0];
  assign boff = a - BANK_BASE;
  assign in_bank = (a >= BANK_BASE) &&
                   (boff < 20'(NBANK) * BANK_STRIDE);
  assign bidx = boff[7:5];
  assign boffs = boff[4:0];
  assign unused_ok = ^{bus.sys_addr[31:20], bus.sys_wdata};

  hk_dna_reader #(
    .DNA(DNA),
    .DNA_DIV(DNA_DIV)
  ) u_dna (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .dna_value_o(dna_val),
    .dna_done_o(dna_done)
  );

  assign rd_acc[0] = '0;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic sel, wr;
    logic [DWE-1:0] dir_q, out_q, ren_q, fen_q, sts_q;
    logic [DWE-1:0] s1_q, s2_q, prv_q, val, w, set_v, clr;
    logic [31:0] rd;

    assign sel = in_bank && (bidx == 3'(b));
    assign wr = sel && bus.sys_wen;
    assign w = bus.sys_wdata[DWE-1:0];

    // two-flop synchroniser and previous value for edges
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        s1_q <= '0;
        s2_q <= '0;
        prv_q <= '0;
      end else begin
        s1_q <= exp_dat_i[b*DWE +: DWE];
        s2_q <= s1_q;
        prv_q <= val;
      end
    end

`ifdef HK_GPIO_DEBOUNCE_EN
    for (genvar i = 0; i < DWE; i++) begin : g_deb
      logic [3:0] cnt_q;
      logic deb_q;
      // take a new level only after HK_DEB_CYC differing cycles
      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          cnt_q <= '0;
          deb_q <= 1'b0;
        end else if (s2_q[i] == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == 4'(HK_DEB_CYC-1)) begin
          deb_q <= s2_q[i];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
      assign val[i] = deb_q;
    end
`else
    assign val = s2_q;
`endif

    assign set_v = (val & ~prv_q & ren_q) |
                   (~val & prv_q & fen_q);
    assign clr = (wr && boffs == B_STS) ? w : '0;

    // bank registers; a new edge beats a same-cycle clear
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        dir_q <= '0;
        out_q <= '0;
        ren_q <= '0;
        fen_q <= '0;
        sts_q <= '0;
      end else begin
        sts_q <= (sts_q & ~clr) | set_v;
        if (wr) begin
          case (boffs)
            B_DIR: dir_q <= w;
            B_OUT: out_q <= w;
            B_REN: ren_q <= w;
            B_FEN: fen_q <= w;
            B_SET: out_q <= out_q | w;
            B_CLR: out_q <= out_q & ~w;
            default: ;
          endcase
        end
      end
    end

    // bank read mux; set/clear strobes read as zero
    always_comb begin
      rd = '0;
      if (sel) begin
        case (boffs)
          B_DIR: rd = 32'(dir_q);
          B_OUT: rd = 32'(out_q);
          B_IN: rd = 32'(val);
          B_REN: rd = 32'(ren_q);
          B_FEN: rd = 32'(fen_q);
          B_STS: rd = 32'(sts_q);
          default: rd = '0;
        endcase
      end
    end

    assign rd_acc[b+1] = rd_acc[b] | rd;
    assign bank_irq[b] = |sts_q;
    assign exp_dat_o[b*DWE +: DWE] = out_q;
    assign exp_dir_o[b*DWE +: DWE] = dir_q;
  end

  // global writable registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      led_q <= '0;
      loop_q <= 1'b0;
    end else if (bus.sys_wen) begin
      if (a == A_LED) led_q <= bus.sys_wdata[DWL-1:0];
      if (a == A_LOOP) loop_q <= bus.sys_wdata[0];
    end
  end

  // global read mux; banks fall through the default
  always_comb begin
    rdata_d = rd_acc[NBANK];
    case (a)
      A_ID: rdata_d = {HK_VER, 8'(NBANK), 8'(DWE), 8'h01};
      A_DNA_LO: rdata_d = dna_val[31:0];
      A_DNA_HI: rdata_d = {dna_done, 6'b0, dna_val[56:32]};
      A_LOOP: rdata_d = {31'b0, loop_q};
      A_LED: rdata_d = 32'(led_q);
      A_RDY: rdata_d = {31'b0, rdy_q};
      default: ;
    endcase
  end

  // bus response, ready flag and registered interrupt
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ack_q <= 1'b0;
      rdata_q <= '0;
      rdy_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ack_q <= bus.sys_wen | bus.sys_ren;
      rdata_q <= bus.sys_ren ? rdata_d : '0;
      rdy_q <= 1'b1;
      irq_q <= |bank_irq;
    end
  end

  assign bus.sys_ack = ack_q;
  assign bus.sys_rdata = rdata_q;
  assign bus.sys_err = 1'b0;
  assign led_o = led_q;
  assign digital_loop = loop_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_red_pitaya_hk_gpio.sv
// tb_red_pitaya_hk_gpio: directed vectors for
// DNA readout, GPIO banks, interrupts and bus decode.
module tb_red_pitaya_hk_gpio;
  localparam int DWL = 8;
  localparam int DWE = 8;
  localparam int NBANK = 2;
  localparam int DNA_DIV = 8;
  localparam logic [56:0] DNA_C = 57'h0823456789ABCDE;
  localparam int DONE_EDGE = 58 * DNA_DIV + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [DWL-1:0] led;
  logic loop_o, irq;
  logic [NBANK*DWE-1:0] din = '0;
  logic [NBANK*DWE-1:0] dout, ddir;
  int n_vec = 0;
  int n_err = 0;

  red_pitaya_hk_gpio_if bus();

  red_pitaya_hk_gpio #(
    .DWL(DWL),
    .DWE(DWE),
    .NBANK(NBANK),
    .DNA(DNA_C),
    .DNA_DIV(DNA_DIV)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .led_o(led),
    .digital_loop(loop_o),
    .exp_dat_i(din),
    .exp_dat_o(dout),
    .exp_dir_o(ddir),
    .irq_o(irq),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [31:0] ad, input logic [31:0] d);
    @(negedge clk);
    bus.sys_addr = ad;
    bus.sys_wdata = d;
    bus.sys_wen = 1'b1;
    @(posedge clk);
    #1 bus.sys_wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] ad,
                        output logic [31:0] d, output logic ak);
    @(negedge clk);
    bus.sys_addr = ad;
    bus.sys_ren = 1'b1;
    @(posedge clk);
    #1 bus.sys_ren = 1'b0;
    d = bus.sys_rdata;
    ak = bus.sys_ack;
  endtask

  task automatic poll_done(output int found);
    found = 0;
    bus.sys_addr = 32'h8;
    bus.sys_ren = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      @(posedge clk);
      #1;
      if (bus.sys_rdata[31]) begin
        found = k;
        break;
      end
    end
    bus.sys_ren = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({led, loop_o, irq, dout, ddir} !== '0) begin
      n_err++;
      $display("FAIL reset_out got %h want 0",
               {led, loop_o, irq, dout, ddir});
    end
    n_vec++;
    if ({bus.sys_ack, bus.sys_err, bus.sys_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_bus got %h want 0",
               {bus.sys_ack, bus.sys_err, bus.sys_rdata});
    end
  endtask

  task automatic test_dna();
    int f;
    logic [31:0] d;
    logic ak;
    @(negedge clk);
    rstn = 1'b1;
    poll_done(f);
    n_vec++;
    if (f !== DONE_EDGE) begin
      n_err++;
      $display("FAIL dna_done_edge got %0d want %0d", f, DONE_EDGE);
    end
    bus_rd(32'h4, d, ak);
    n_vec++;
    if (d !== DNA_C[31:0]) begin
      n_err++;
      $display("FAIL dna_lo got %h want %h", d, DNA_C[31:0]);
    end
    bus_rd(32'h8, d, ak);
    n_vec++;
    if (d !== {1'b1, 6'b0, DNA_C[56:32]}) begin
      n_err++;
      $display("FAIL dna_hi got %h want %h", d,
               {1'b1, 6'b0, DNA_C[56:32]});
    end
  endtask

  task automatic test_id();
    logic [31:0] d;
    logic ak;
    bus_rd(32'h0, d, ak);
    n_vec++;
    if (d !== 32'h02020801) begin
      n_err++;
      $display("FAIL id got %h want 02020801", d);
    end
    bus_rd(32'hFFF0_0000, d, ak);
    n_vec++;
    if (d !== 32'h02020801) begin
      n_err++;
      $display("FAIL id_alias got %h want 02020801", d);
    end
    bus_rd(32'h100, d, ak);
    n_vec++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL fpga_rdy got %h want 1", d);
    end
  endtask

  task automatic test_led_loop();
    logic [31:0] d;
    logic ak;
    bus_wr(32'h30, 32'h1A5);
    n_vec++;
    if (led !== 8'hA5) begin
      n_err++;
      $display("FAIL led_o got %h want a5", led);
    end
    bus_rd(32'h30, d, ak);
    n_vec++;
    if (d !== 32'hA5) begin
      n_err++;
      $display("FAIL led_rd got %h want a5", d);
    end
    bus_wr(32'hC, 32'hFFFF_FFFF);
    bus_rd(32'hC, d, ak);
    n_vec++;
    if ({loop_o, d} !== {1'b1, 32'h1}) begin
      n_err++;
      $display("FAIL loop got %b/%h want 1/1", loop_o, d);
    end
  endtask

  task automatic test_atomic();
    logic [31:0] d;
    logic ak;
    bus_wr(32'h220, 32'h3C);
    n_vec++;
    if (ddir !== 16'h3C00) begin
      n_err++;
      $display("FAIL dir_o got %h want 3c00", ddir);
    end
    bus_wr(32'h224, 32'hF0);
    bus_wr(32'h238, 32'h0F);
    bus_rd(32'h224, d, ak);
    n_vec++;
    if (d !== 32'hFF || dout !== 16'hFF00) begin
      n_err++;
      $display("FAIL out_set got %h/%h want ff/ff00", d, dout);
    end
    bus_wr(32'h23C, 32'h81);
    bus_rd(32'h224, d, ak);
    n_vec++;
    if (d !== 32'h7E || dout !== 16'h7E00) begin
      n_err++;
      $display("FAIL out_clr got %h/%h want 7e/7e00", d, dout);
    end
    bus_rd(32'h238, d, ak);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL set_rd got %h want 0", d);
    end
  endtask

  task automatic test_inputs();
    logic [31:0] d;
    logic ak;
    @(negedge clk);
    din[15:8] = 8'h5A;
    repeat (3) @(posedge clk);
    bus_rd(32'h228, d, ak);
    n_vec++;
    if (d !== 32'h5A) begin
      n_err++;
      $display("FAIL in_rd got %h want 5a", d);
    end
    @(negedge clk);
    din[15:8] = 8'hC3;
    bus_rd(32'h228, d, ak);
    n_vec++;
    if (d !== 32'h5A) begin
      n_err++;
      $display("FAIL in_lat1 got %h want 5a", d);
    end
    bus_rd(32'h228, d, ak);
    n_vec++;
    if (d !== 32'hC3) begin
      n_err++;
      $display("FAIL in_lat2 got %h want c3", d);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    logic ak;
    int hit;
    bus_wr(32'h20C, 32'h01);
    @(negedge clk);
    din[0] = 1'b1;
    hit = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        hit = k;
        break;
      end
    end
    n_vec++;
    if (hit == 0) begin
      n_err++;
      $display("FAIL irq_rise got 0 want 1 within 4 cycles");
    end
    bus_rd(32'h214, d, ak);
    n_vec++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL sts_rise got %h want 1", d);
    end
    bus_wr(32'h214, 32'h1);
    @(posedge clk);
    #1;
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_w1c got %b want 0", irq);
    end
    @(negedge clk);
    din[0] = 1'b0;
    repeat (5) @(posedge clk);
    bus_rd(32'h214, d, ak);
    n_vec++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL fall_off got %h/%b want 0/0", d, irq);
    end
  endtask

  task automatic test_fall();
    logic [31:0] d;
    logic ak;
    bus_wr(32'h210, 32'h02);
    @(negedge clk);
    din[1] = 1'b1;
    repeat (4) @(posedge clk);
    bus_rd(32'h214, d, ak);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL fall_rise got %h want 0", d);
    end
    @(negedge clk);
    din[1] = 1'b0;
    repeat (4) @(posedge clk);
    bus_rd(32'h214, d, ak);
    n_vec++;
    if (d !== 32'h2 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL fall_sts got %h/%b want 2/1", d, irq);
    end
    bus_wr(32'h214, 32'hFF);
    repeat (2) @(posedge clk);
    bus_rd(32'h214, d, ak);
    n_vec++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL fall_clr got %h/%b want 0/0", d, irq);
    end
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] d;
    logic ak;
    @(negedge clk);
    din[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus_wr(32'h214, 32'h1);
    bus_rd(32'h214, d, ak);
    n_vec++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL set_beats_clr got %h want 1", d);
    end
    bus_wr(32'h214, 32'h1);
    bus_rd(32'h214, d, ak);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL sts_clr2 got %h want 0", d);
    end
    @(negedge clk);
    din[0] = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic ak;
    bus_rd(32'h300, d, ak);
    n_vec++;
    if ({ak, bus.sys_err, d} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL unmap_300 got %b/%b/%h want 1/0/0",
               ak, bus.sys_err, d);
    end
    bus_rd(32'h050, d, ak);
    n_vec++;
    if ({ak, d} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL unmap_050 got %b/%h want 1/0", ak, d);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.sys_ack !== 1'b0) begin
      n_err++;
      $display("FAIL ack_drop got %b want 0", bus.sys_ack);
    end
    bus_wr(32'h300, 32'hFFFF);
    bus_wr(32'h208, 32'hFF);
    bus_rd(32'h208, d, ak);
    n_vec++;
    if (d !== 32'h0 || dout !== 16'h7E00 || ddir !== 16'h3C00) begin
      n_err++;
      $display("FAIL ro_write got %h/%h/%h want 0/7e00/3c00",
               d, dout, ddir);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    logic ak;
    int f;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (199) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    bus.sys_addr = 32'h4;
    bus.sys_ren = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.sys_rdata !== 32'h0 || dout !== '0) begin
      n_err++;
      $display("FAIL mid_rst_val got %h/%h want 0/0",
               bus.sys_rdata, dout);
    end
    poll_done(f);
    n_vec++;
    if (f !== DONE_EDGE - 1) begin
      n_err++;
      $display("FAIL mid_done_edge got %0d want %0d",
               f, DONE_EDGE - 1);
    end
    bus_rd(32'h4, d, ak);
    n_vec++;
    if (d !== DNA_C[31:0]) begin
      n_err++;
      $display("FAIL mid_dna_lo got %h want %h", d, DNA_C[31:0]);
    end
    bus_rd(32'h8, d, ak);
    n_vec++;
    if (d !== {1'b1, 6'b0, DNA_C[56:32]}) begin
      n_err++;
      $display("FAIL mid_dna_hi got %h want %h", d,
               {1'b1, 6'b0, DNA_C[56:32]});
    end
  endtask

  initial begin
    bus.sys_addr = '0;
    bus.sys_wdata = '0;
    bus.sys_wen = 1'b0;
    bus.sys_ren = 1'b0;
    test_reset();
    test_dna();
    test_id();
    test_led_loop();
    test_atomic();
    test_inputs();
    test_edge_irq();
    test_fall();
    test_set_beats_clear();
    test_unmapped();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
